// File: rtl/vlc_pkg.sv
// Shared types and defaults for the VLC transmit frame scheduler.
package vlc_pkg;

    localparam int          DEF_WORD_BITS = 32;
    localparam logic [31:0] DEF_PREAMBLE  = 32'hAAAA_AAAB;
    localparam logic [7:0]  DEF_HDR_TAG   = 8'hA5;
    localparam logic [31:0] DEF_FILL_WORD = 32'h0000_0000;
    localparam int          DEF_GAP_SLOTS = 2;

    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, GAP} state_t;

    // Header word layout, MSB first: tag, sequence, length, inverted length.
    typedef struct packed {
        logic [7:0] tag;
        logic [7:0] seq;
        logic [7:0] len;
        logic [7:0] lenN;
    } hdr_t;

    function automatic logic [31:0] mkHeader(input logic [7:0] tag, input logic [7:0] seq,
                                             input logic [7:0] len);
        hdr_t h;
        h.tag  = tag;
        h.seq  = seq;
        h.len  = len;
        h.lenN = ~len;
        return h;
    endfunction

endpackage

// File: rtl/vlc_slot_timer.sv
// Mod-WORD_BITS slot counter; held at 0 while disabled so a frame always starts on count 0.
module vlc_slot_timer #(
    parameter int WORD_BITS = 32,
    parameter int CW        = $clog2(WORD_BITS)
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iEn,
    output logic oSlotStart,
    output logic oPrefetch,
    output logic oCapture,
    output logic oWrap
);

    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset)           cnt <= '0;
        else if (!iEn)        cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + 1'b1;
    end

    assign oSlotStart = iEn && (cnt == '0);
    assign oPrefetch  = iEn && (cnt == CW'(WORD_BITS - 2));
    assign oCapture   = iEn && (cnt == LAST);
    assign oWrap      = iEn && (cnt == LAST);

endmodule

// File: rtl/vlc_tx_frame_ctrl.sv
// Frame scheduler: preamble, header, len payload words from the TX FIFO, then a silent gap.
module vlc_tx_frame_ctrl
    import vlc_pkg::*;
#(
    parameter int          WORD_BITS = DEF_WORD_BITS,
    parameter logic [31:0] PREAMBLE  = DEF_PREAMBLE,
    parameter logic [7:0]  HDR_TAG   = DEF_HDR_TAG,
    parameter logic [31:0] FILL_WORD = DEF_FILL_WORD,
    parameter int          GAP_SLOTS = DEF_GAP_SLOTS
) (
    input  logic        iClk,
    input  logic        iReset,
    input  logic        iStart,
    input  logic [7:0]  iLen,
    input  logic        iFifo_empty,
    input  logic [31:0] iFifo_data,
    output logic        oFifo_rd,
    output logic [31:0] oSer_word,
    output logic        oSer_load,
    output logic        oBusy,
    output logic        oDone,
    output logic        oUnderrun,
    output logic [7:0]  oSeq
);

    localparam int GW = (GAP_SLOTS > 1) ? $clog2(GAP_SLOTS) : 1;

    state_t          state;
    logic [7:0]      lenQ;
    logic [7:0]      wordsLeft;
    logic [GW-1:0]   gapCnt;
    logic            rdIssued;
    logic            tStart, tPrefetch, tCapture, tWrap;
    logic            prefetchSlot;
    logic [31:0]     payWord;

    vlc_slot_timer #(.WORD_BITS(WORD_BITS)) uTimer (
        .iClk       (iClk),
        .iReset     (iReset),
        .iEn        (state != IDLE),
        .oSlotStart (tStart),
        .oPrefetch  (tPrefetch),
        .oCapture   (tCapture),
        .oWrap      (tWrap)
    );

    // Prefetch only ahead of a payload slot; never during the last payload slot.
    assign prefetchSlot = tPrefetch && (((state == HDR) && (lenQ != 8'd0)) ||
                                        ((state == PAY) && (wordsLeft > 8'd1)));
    assign oFifo_rd     = prefetchSlot && !iFifo_empty;
    assign payWord      = (tCapture && rdIssued) ? iFifo_data : FILL_WORD;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            state     <= IDLE;
            lenQ      <= '0;
            wordsLeft <= '0;
            gapCnt    <= '0;
            rdIssued  <= 1'b0;
            oSer_word <= '0;
            oSer_load <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oUnderrun <= 1'b0;
            oSeq      <= '0;
        end else begin
            oSer_load <= 1'b0;
            oDone     <= 1'b0;
            if (tStart) rdIssued <= 1'b0;
            if (prefetchSlot) begin
                rdIssued <= !iFifo_empty;
                if (iFifo_empty) oUnderrun <= 1'b1;
            end
            case (state)
                IDLE: if (iStart) begin
                    lenQ      <= iLen;
                    oBusy     <= 1'b1;
                    oUnderrun <= 1'b0;
                    oSer_load <= 1'b1;
                    oSer_word <= PREAMBLE;
                    state     <= PRE;
                end
                PRE: if (tWrap) begin
                    oSer_load <= 1'b1;
                    oSer_word <= mkHeader(HDR_TAG, oSeq, lenQ);
                    state     <= HDR;
                end
                HDR: if (tWrap) begin
                    if (lenQ != 8'd0) begin
                        wordsLeft <= lenQ;
                        oSer_load <= 1'b1;
                        oSer_word <= payWord;
                        state     <= PAY;
                    end else begin
                        gapCnt <= '0;
                        state  <= GAP;
                    end
                end
                PAY: if (tWrap) begin
                    wordsLeft <= wordsLeft - 8'd1;
                    if (wordsLeft == 8'd1) begin
                        gapCnt <= '0;
                        state  <= GAP;
                    end else begin
                        oSer_load <= 1'b1;
                        oSer_word <= payWord;
                    end
                end
                GAP: if (tWrap) begin
                    if (gapCnt == GW'(GAP_SLOTS - 1)) begin
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                        oSeq  <= oSeq + 8'd1;
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vlc_tx_frame_ctrl.sv
// Scoreboard bench for vlc_tx_frame_ctrl: expected loads/reads/done pushed at start, popped by a monitor.
module tb_vlc_tx_frame_ctrl;

    typedef struct {
        int          c;
        logic [31:0] w;
    } ld_t;

    logic        iClk, iReset, iStart, iFifo_empty, oFifo_rd, oSer_load, oBusy, oDone, oUnderrun;
    logic [7:0]  iLen, oSeq;
    logic [31:0] iFifo_data, oSer_word;

    int          cyc = 0;
    int          errCnt = 0;
    int          chkCnt = 0;
    int          rdCnt = 0;
    logic [7:0]  seqModel = 8'd0;
    logic [31:0] fifoMem[$];
    ld_t         loadQ[$];
    int          rdQ[$];
    int          doneQ[$];
    ld_t         mE;
    int          mC;

    vlc_tx_frame_ctrl dut (
        .iClk        (iClk),
        .iReset      (iReset),
        .iStart      (iStart),
        .iLen        (iLen),
        .iFifo_empty (iFifo_empty),
        .iFifo_data  (iFifo_data),
        .oFifo_rd    (oFifo_rd),
        .oSer_word   (oSer_word),
        .oSer_load   (oSer_load),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oUnderrun   (oUnderrun),
        .oSeq        (oSeq)
    );

    always #5 iClk = ~iClk;
    always @(posedge iClk) cyc <= cyc + 1;

    // FIFO model: read data appears the cycle after the strobe.
    assign iFifo_empty = (rdCnt >= fifoMem.size());
    always @(posedge iClk) begin
        if (oFifo_rd && !iReset) begin
            iFifo_data <= fifoMem[rdCnt];
            rdCnt      <= rdCnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge iClk) begin
        if (!iReset) begin
            if (oSer_load) begin
                if (loadQ.size() == 0) chk("load_extra", 32'(oSer_word), 32'hFFFF_FFFF);
                else begin
                    mE = loadQ.pop_front();
                    chk("load_word", oSer_word, mE.w);
                    chk("load_cyc", 32'(cyc), 32'(mE.c));
                end
            end
            if (oFifo_rd) begin
                if (rdQ.size() == 0) chk("rd_extra", 32'(cyc), 32'hFFFF_FFFF);
                else begin
                    mC = rdQ.pop_front();
                    chk("rd_cyc", 32'(cyc), 32'(mC));
                end
            end
            if (oDone) begin
                if (doneQ.size() == 0) chk("done_extra", 32'(cyc), 32'hFFFF_FFFF);
                else begin
                    mC = doneQ.pop_front();
                    chk("done_cyc", 32'(cyc), 32'(mC));
                end
            end
        end
    end

    // Push expectations for one frame accepted at the next edge; returns that edge's cycle.
    task automatic pushFrame(input int len, input int nPay, output int s, output int avail);
        logic [7:0] l8;
        l8    = 8'(len);
        s     = cyc + 1;
        avail = fifoMem.size() - rdCnt;
        loadQ.push_back('{s, 32'hAAAA_AAAB});
        loadQ.push_back('{s + 32, {8'hA5, seqModel, l8, ~l8}});
        for (int k = 0; k < nPay; k++) begin
            loadQ.push_back('{s + (2 + k) * 32, (k < avail) ? fifoMem[rdCnt + k] : 32'h0});
            if (k < avail) rdQ.push_back(s + (1 + k) * 32 + 30);
        end
        iLen   = l8;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        chk("busy_start", 32'(oBusy), 32'd1);
        chk("unr_clear", 32'(oUnderrun), 32'd0);
    endtask

    task automatic runFrame(input int len, input bit midPulse);
        int s, avail, rd0, nRd;
        bit got;
        @(negedge iClk);
        rd0 = rdCnt;
        pushFrame(len, len, s, avail);
        doneQ.push_back(s + (2 + len) * 32 + 64);
        nRd = (avail < len) ? avail : len;
        got = 0;
        for (int i = 0; i < (len + 4) * 32 + 100; i++) begin
            @(negedge iClk);
            iStart = midPulse && (cyc == s + 69);
            if (iStart) iLen = 8'd7;
            if (oDone) begin
                got = 1;
                break;
            end
        end
        iStart = 1'b0;
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        seqModel = seqModel + 8'd1;
        @(negedge iClk);
        chk("seq", 32'(oSeq), 32'(seqModel));
        chk("underrun", 32'(oUnderrun), 32'(avail < len));
        chk("rd_count", 32'(rdCnt - rd0), 32'(nRd));
        chk("busy_end", 32'(oBusy), 32'd0);
        chk("q_left", 32'(loadQ.size() + rdQ.size() + doneQ.size()), 32'd0);
        loadQ.delete();
        rdQ.delete();
        doneQ.delete();
    endtask

    task automatic chkZero(input string tag);
        chk({tag, "_load"}, 32'(oSer_load), 32'd0);
        chk({tag, "_rd"}, 32'(oFifo_rd), 32'd0);
        chk({tag, "_busy"}, 32'(oBusy), 32'd0);
        chk({tag, "_done"}, 32'(oDone), 32'd0);
        chk({tag, "_unr"}, 32'(oUnderrun), 32'd0);
        chk({tag, "_seq"}, 32'(oSeq), 32'd0);
        chk({tag, "_word"}, oSer_word, 32'd0);
    endtask

    task automatic resetAbort();
        int s, avail;
        @(negedge iClk);
        fifoMem.push_back(32'hA1);
        fifoMem.push_back(32'hA2);
        fifoMem.push_back(32'hA3);
        pushFrame(3, 1, s, avail);
        for (int i = 0; i < 200 && cyc < s + 74; i++) @(negedge iClk);
        iReset = 1'b1;
        #1;
        chkZero("abort");
        repeat (3) @(negedge iClk);
        iReset = 1'b0;
        repeat (80) @(negedge iClk);
        chk("abort_q_left", 32'(loadQ.size() + rdQ.size()), 32'd0);
        loadQ.delete();
        rdQ.delete();
        seqModel = 8'd0;
    endtask

    initial begin
        iClk = 1'b0; iReset = 1'b1; iStart = 1'b0; iLen = 8'd0;
        repeat (3) @(negedge iClk);
        chkZero("reset");
        iReset = 1'b0;

        fifoMem.push_back(32'h11);
        fifoMem.push_back(32'h22);
        fifoMem.push_back(32'h33);
        runFrame(3, 0);
        runFrame(0, 0);
        fifoMem.push_back(32'h44);
        runFrame(2, 0);
        repeat (5) @(negedge iClk);
        chk("unr_sticky", 32'(oUnderrun), 32'd1);
        fifoMem.push_back(32'h55);
        fifoMem.push_back(32'h66);
        fifoMem.push_back(32'h77);
        runFrame(3, 1);

        resetAbort();
        runFrame(1, 0);

        for (int f = 0; f < 256; f++) begin
            fifoMem.push_back($urandom);
            runFrame(1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
